stepper_move_sequencer: RTL and testbench
=========================================

// Module: stepper_move_sequencer
// PURPOSE
//  Trapezoidal-profile move sequencer for the forklift stepper channel. It accepts move
//  commands (direction, step count, speed and ramp settings) from the HPS-side register block.
//  It times each step and drives the 6-bit L298N-style coil bus {ENB,ENA,IN4,IN3,IN2,IN1}.
//  It also keeps a signed absolute position count that the HPS uses for lift-height tracking.
// PARAMETERS
//  CNT_W   24  width of step-count field
//  PER_W   20  width of step-period fields, unit = clk cycles
//  POS_W   32  width of signed position counter
// PORTS
//  clk             in   1      system clock; single clock domain
//  reset_n         in   1      asynchronous, active-low reset
//  cmd_valid       in   1      move command present
//  cmd_ready       out  1      high only in IDLE; command is accepted on cmd_valid&&cmd_ready
//  cmd_dir         in   1      1 = forward (+position), 0 = reverse
//  cmd_half        in   1      1 = half-step (8 phases), 0 = full-step two-coil (odd phases)
//  cmd_steps       in   CNT_W  number of steps to take
//  cmd_start_per   in   PER_W  first/slowest step interval
//  cmd_min_per     in   PER_W  cruise/fastest step interval
//  cmd_accel_dec   in   PER_W  interval change per step while ramping
//  abort           in   1      stop the move at once; level-sampled every cycle
//  hold_en         in   1      1 = keep coils energised while idle
//  busy            out  1      high whenever the FSM is not IDLE
//  done            out  1      one-cycle pulse at move end (normal, zero-length or abort)
//  position        out  POS_W  signed step position
//  phase_out       out  6      {ENB,ENA,IN4,IN3,IN2,IN1}
// BEHAVIOUR
//  Reset values: phase_out=0, busy=0, done=0, position=0, phase idx=0, FSM=IDLE.
//  cmd_ready=1 out of reset.
//  Command latch: all cmd_* fields are latched on acceptance.
//  - Latched min_per is clamped to max(cmd_min_per, 2) and to at most start_per.
//  - Latched start_per is clamped to at least 2.
//  - cmd_valid while busy is ignored; no queuing.
//  FSM: IDLE -> RUN -> FINISH -> IDLE.
//  - IDLE -> FINISH directly when cmd_steps=0.
//  - RUN -> FINISH on the final step or when abort=1.
//  - FINISH lasts 1 cycle and asserts done there.
//  - Abort leaves phase idx and position at their last values.
//  Timing: on acceptance, cur_per=start_per, timer=start_per-1, rem=steps, ramp_cnt=0.
//  - A step fires when timer==0, so the first phase change comes start_per cycles after acceptance.
//  - Each step reloads timer with the new interval minus 1.
//  Per step, with rem' = rem-1:
//  - position += dir ? +1 : -1, wrapping at POS_W.
//  - if rem' <= ramp_cnt: cur_per = min(cur_per+accel_dec, start_per) (decel).
//  - else if cur_per > min_per: cur_per = max(cur_per-accel_dec, min_per); ramp_cnt++ (accel).
//  - else: cur_per is unchanged (cruise).
//  Arithmetic is done at PER_W+1 bits with saturation, so there is no wrap.
//  The profile is palindromic, and short moves degrade to a triangle.
//  accel_dec=0 gives constant speed.
//  Phase index (3 bit, mod 8):
//  - half-step: idx +/- 1.
//  - full-step: (idx|1) +/- 2.
//  Phase table, idx0..7 = A+, A+B+, B+, A-B+, A-, A-B-, B-, A+B-.
//  - A+ means IN1=1, IN2=0; A- means IN1=0, IN2=1; same for B on IN3/IN4.
//  - ENA/ENB=1 only when that coil is driven; an undriven coil has EN and IN bits all 0.
//  - phase_out is registered and updates the cycle after the step fires.
//  Idle output: phase_out = table[idx] if hold_en=1, else 0. Same rule in FINISH.
//  Reset asserted mid-move: immediate return to reset values, and position is lost.
// STRUCTURE
//  stepper_pkg holds:
//  - FSM state enum;
//  - 8x6 PHASE_TABLE constant;
//  - phase_out bit-index localparams.
//  Sub-module stepper_phase_lut is combinational and maps idx + energise to the 6-bit pattern.
//  Everything else (timer, ramp, position, FSM) lives in this module.
// TESTING
//  1 Reset -> phase_out=0, busy=0, cmd_ready=1, position=0; hold_en=1 idle -> phase_out=6'b010001.
//  2 start=min=100, dec=0, steps=4, dir=1, half -> steps at +100/+200/+300/+400;
//    idx 1,2,3,4; done 1 cycle after step 4; position=4.
//  3 start=1000, min=400, dec=100, steps=20 -> intervals 1000..500 (6), 400 x8,
//    then 500..1000 (6); position=20.
//  4 start=1000, min=100, dec=100, steps=5 -> intervals 1000,900,800,900,1000 (triangle).
//  5 From reset, dir=0, full, start=min=50, steps=3 -> idx 7,5,3; position=-3.
//  6 Abort during step 3 of 10 -> done next cycle, position=2, phase held.
//    steps=0 -> done 1 cycle after accept.
//    cmd_valid while busy -> ignored.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move sequencer: FSM states,
// coil-bus bit positions and the 8-entry phase pattern table.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int PH_IN1 = 0;
    localparam int PH_IN2 = 1;
    localparam int PH_IN3 = 2;
    localparam int PH_IN4 = 3;
    localparam int PH_ENA = 4;
    localparam int PH_ENB = 5;

    // Bus order {ENB,ENA,IN4,IN3,IN2,IN1}; index 0..7 walks A+, A+B+, B+, ... A+B-
    localparam logic [5:0] PHASE_TABLE [8] = '{
        6'b010001,
        6'b110101,
        6'b100100,
        6'b110110,
        6'b010010,
        6'b111010,
        6'b101000,
        6'b111001
    };

    function automatic logic [2:0] next_phase_idx(
        input logic [2:0] idx,
        input logic       dir,
        input logic       half
    );
        logic [2:0] base;
        logic [2:0] delta;
        base  = half ? idx : (idx | 3'd1);
        delta = half ? 3'd1 : 3'd2;
        return dir ? (base + delta) : (base - delta);
    endfunction

endpackage

// File: rtl/stepper_phase_lut.sv
// Combinational map from phase index and energise flag to the 6-bit coil bus.
module stepper_phase_lut
    import stepper_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       energise,
    output logic [5:0] pattern
);

    logic [5:0] raw;

    assign raw = PHASE_TABLE[idx];

    // IN bits are gated by their coil enable so an undriven coil is fully quiet
    always_comb begin
        pattern = '0;
        if (energise) begin
            pattern[PH_ENA] = raw[PH_ENA];
            pattern[PH_ENB] = raw[PH_ENB];
            pattern[PH_IN1] = raw[PH_ENA] & raw[PH_IN1];
            pattern[PH_IN2] = raw[PH_ENA] & raw[PH_IN2];
            pattern[PH_IN3] = raw[PH_ENB] & raw[PH_IN3];
            pattern[PH_IN4] = raw[PH_ENB] & raw[PH_IN4];
        end
    end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Trapezoidal-profile stepper move sequencer: step timing, ramping, phase
// sequencing and signed position tracking for one L298N-style channel.
module stepper_move_sequencer
    import stepper_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int PER_W = 20,
    parameter int POS_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic                    cmd_half,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [PER_W-1:0]        cmd_start_per,
    input  logic [PER_W-1:0]        cmd_min_per,
    input  logic [PER_W-1:0]        cmd_accel_dec,
    input  logic                    abort,
    input  logic                    hold_en,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position,
    output logic [5:0]              phase_out
);

    state_t            state, state_d;
    logic [2:0]        idx, idx_d;
    logic              accept;
    logic              step_fire;
    logic              energise;
    logic [5:0]        pattern_d;

    logic [PER_W-1:0]  start_l, min_l, dec_l;
    logic              dir_l, half_l;
    logic [PER_W-1:0]  cur_per, timer, per_next;
    logic [CNT_W-1:0]  rem, ramp_cnt, rem_dec;
    logic              accel;
    logic [PER_W-1:0]  start_c, min_c;
    logic signed [POS_W-1:0] step_inc;

    function automatic logic [PER_W-1:0] floor_two(input logic [PER_W-1:0] v);
        return (v < PER_W'(2)) ? PER_W'(2) : v;
    endfunction

    function automatic logic [PER_W-1:0] sat_add_cap(
        input logic [PER_W-1:0] a,
        input logic [PER_W-1:0] b,
        input logic [PER_W-1:0] cap
    );
        logic [PER_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, cap}) ? cap : sum[PER_W-1:0];
    endfunction

    function automatic logic [PER_W-1:0] sat_sub_floor(
        input logic [PER_W-1:0] a,
        input logic [PER_W-1:0] b,
        input logic [PER_W-1:0] floor_v
    );
        logic signed [PER_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < $signed({1'b0, floor_v})) ? floor_v : diff[PER_W-1:0];
    endfunction

    assign start_c = floor_two(cmd_start_per);
    assign min_c   = (floor_two(cmd_min_per) > start_c) ? start_c : floor_two(cmd_min_per);
    assign rem_dec = rem - CNT_W'(1);
    assign step_inc = dir_l ? POS_W'(1) : {POS_W{1'b1}};

    // Control: next state, handshake and status outputs
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        step_fire = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = (cmd_steps == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (timer == '0) begin
                    step_fire = 1'b1;
                    if (rem_dec == '0) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ramp decision for the interval that follows the current step
    always_comb begin
        accel    = 1'b0;
        per_next = cur_per;
        if (rem_dec <= ramp_cnt) begin
            per_next = sat_add_cap(cur_per, dec_l, start_l);
        end else if (cur_per > min_l) begin
            per_next = sat_sub_floor(cur_per, dec_l, min_l);
            accel    = 1'b1;
        end
    end

    assign idx_d    = step_fire ? next_phase_idx(idx, dir_l, half_l) : idx;
    assign energise = (state_d == ST_RUN) || hold_en;

    stepper_phase_lut u_lut (
        .idx      (idx_d),
        .energise (energise),
        .pattern  (pattern_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            position  <= '0;
            phase_out <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            phase_out <= pattern_d;
            if (step_fire) begin
                position <= position + step_inc;
            end
        end
    end

    // Move datapath: only meaningful after a command has been accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            start_l  <= start_c;
            min_l    <= min_c;
            dec_l    <= cmd_accel_dec;
            dir_l    <= cmd_dir;
            half_l   <= cmd_half;
            cur_per  <= start_c;
            timer    <= start_c - PER_W'(1);
            rem      <= cmd_steps;
            ramp_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (step_fire) begin
                rem     <= rem_dec;
                cur_per <= per_next;
                timer   <= per_next - PER_W'(1);
                if (accel) begin
                    ramp_cnt <= ramp_cnt + CNT_W'(1);
                end
            end else begin
                timer <= timer - PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Scoreboard bench for stepper_move_sequencer: a move-level reference model queues
// expected step/done events; a monitor pops and compares them as the DUT emits them.
module tb_stepper_move_sequencer;

    localparam int CNT_W = 24;
    localparam int PER_W = 20;
    localparam int POS_W = 32;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic                    cmd_dir = 1'b0;
    logic                    cmd_half = 1'b0;
    logic [CNT_W-1:0]        cmd_steps = '0;
    logic [PER_W-1:0]        cmd_start_per = '0;
    logic [PER_W-1:0]        cmd_min_per = '0;
    logic [PER_W-1:0]        cmd_accel_dec = '0;
    logic                    abort = 1'b0;
    logic                    hold_en = 1'b0;
    logic                    busy;
    logic                    done;
    logic signed [POS_W-1:0] position;
    logic [5:0]              phase_out;

    stepper_move_sequencer #(.CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_half      (cmd_half),
        .cmd_steps     (cmd_steps),
        .cmd_start_per (cmd_start_per),
        .cmd_min_per   (cmd_min_per),
        .cmd_accel_dec (cmd_accel_dec),
        .abort         (abort),
        .hold_en       (hold_en),
        .busy          (busy),
        .done          (done),
        .position      (position),
        .phase_out     (phase_out)
    );

    typedef struct {
        bit                is_done;
        int                at;
        logic signed [31:0] pos;
        logic [5:0]        phase;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    logic signed [31:0] m_pos = 0;
    int  m_idx = 0;
    logic signed [31:0] prev_pos = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Coil drive from the electrical angle idx*45deg: A follows cos, B follows sin
    function automatic logic [5:0] coil_bits(input int idx);
        int a, b;
        logic [5:0] r;
        case (idx & 7)
            0, 1, 7: a = 1;
            3, 4, 5: a = -1;
            default: a = 0;
        endcase
        case (idx & 7)
            1, 2, 3: b = 1;
            5, 6, 7: b = -1;
            default: b = 0;
        endcase
        r = '0;
        if (a != 0) begin r[4] = 1'b1; r[0] = (a > 0); r[1] = (a < 0); end
        if (b != 0) begin r[5] = 1'b1; r[2] = (b > 0); r[3] = (b < 0); end
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take_event(input bit is_done);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind=%0d at cycle %0d pos=%0d phase=%b, nothing expected",
                     is_done, cyc, position, phase_out);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_done != is_done || e.at != cyc || e.pos != position || e.phase != phase_out ||
            (is_done && !(busy && !cmd_ready))) begin
            failures++;
            $display("FAIL event: got kind=%0d cyc=%0d pos=%0d phase=%b busy=%0b ready=%0b, expected kind=%0d cyc=%0d pos=%0d phase=%b",
                     is_done, cyc, position, phase_out, busy, cmd_ready, e.is_done, e.at, e.pos, e.phase);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_pos = position;
        end else begin
            if (position != prev_pos) begin
                take_event(1'b0);
                prev_pos = position;
            end
            if (done) take_event(1'b1);
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_phase_out", phase_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_position", position, 0);
        m_pos = 0;
        m_idx = 0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_move(input bit dir, input bit half, input int steps, input int sp,
                            input int mp, input int dec, input bit hold, input int abort_rel,
                            input bit poke, input int reset_rel);
        int s, m, cur, ramp, t, acc, end_rel, poke_rel, rel;
        bit aborted, hit_reset;
        ev_t e;
        s = (sp < 2) ? 2 : sp;
        m = (mp < 2) ? 2 : mp;
        if (m > s) m = s;
        hold_en = hold;
        @(negedge clk);
        acc = cyc + 1;
        cur = s; ramp = 0; t = 0; aborted = 0; hit_reset = 0;
        for (int k = 1; k <= steps; k++) begin
            t += cur;
            if (abort_rel != 0 && abort_rel <= t) begin aborted = 1; break; end
            m_idx = half ? ((m_idx + (dir ? 1 : 7)) & 7) : (((m_idx | 1) + (dir ? 2 : 6)) & 7);
            m_pos = m_pos + (dir ? 32'sd1 : -32'sd1);
            e.is_done = 0;
            e.at      = acc + t;
            e.pos     = m_pos;
            e.phase   = (k == steps && !hold) ? 6'b0 : coil_bits(m_idx);
            exp_q.push_back(e);
            if (steps - k <= ramp) cur = (cur + dec > s) ? s : cur + dec;
            else if (cur > m) begin cur = (cur - dec < m) ? m : cur - dec; ramp++; end
        end
        end_rel   = aborted ? abort_rel : t;
        e.is_done = 1;
        e.at      = acc + end_rel;
        e.pos     = m_pos;
        e.phase   = hold ? coil_bits(m_idx) : 6'b0;
        exp_q.push_back(e);

        cmd_dir       = dir;
        cmd_half      = half;
        cmd_steps     = CNT_W'(steps);
        cmd_start_per = PER_W'(sp);
        cmd_min_per   = PER_W'(mp);
        cmd_accel_dec = PER_W'(dec);
        cmd_valid     = 1'b1;
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        poke_rel  = poke ? int'($urandom_range(end_rel + 1, 1)) : 0;

        for (int i = 0; i < end_rel + 4; i++) begin
            rel = cyc + 1 - acc;
            if (reset_rel != 0 && rel == reset_rel) begin hit_reset = 1; break; end
            abort = (abort_rel != 0 && rel == abort_rel);
            if (rel == poke_rel) begin
                cmd_valid     = 1'b1;
                cmd_dir       = ~dir;
                cmd_half      = ~half;
                cmd_steps     = CNT_W'($urandom_range(9, 1));
                cmd_start_per = PER_W'($urandom_range(9, 2));
                cmd_min_per   = PER_W'(2);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= acc + end_rel + 2) break;
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;

        if (hit_reset) begin
            do_reset();
        end else begin
            check("idle_busy", busy, 0);
            check("idle_cmd_ready", cmd_ready, 1);
            check("idle_done", done, 0);
            check("end_position", position, m_pos);
            check("idle_phase_out", phase_out, hold ? coil_bits(m_idx) : 6'b0);
            check("events_outstanding", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        bit d, h, hd, pk;
        int st, sp, mp, dc, ab;

        do_reset();
        hold_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold_phase", phase_out, 6'b010001);

        run_move(1, 1, 4, 100, 100, 0, 1, 0, 1, 0);
        check("const_speed_position", position, 4);
        run_move(1, 0, 20, 1000, 400, 100, 0, 0, 1, 0);
        check("trapezoid_position", position, 24);
        run_move(0, 1, 5, 1000, 100, 100, 1, 0, 0, 0);

        hold_en = 1'b1;
        do_reset();
        run_move(0, 0, 3, 50, 50, 0, 1, 0, 0, 0);
        check("reverse_full_position", position, -3);
        check("reverse_full_phase", phase_out, 6'b110110);

        do_reset();
        run_move(1, 1, 10, 30, 30, 0, 1, 70, 0, 0);
        check("abort_position", position, 2);
        check("abort_phase_held", phase_out, 6'b100100);
        run_move(1, 1, 0, 10, 10, 0, 1, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            d  = 1'($urandom_range(1, 0));
            h  = 1'($urandom_range(1, 0));
            hd = 1'($urandom_range(1, 0));
            pk = 1'($urandom_range(1, 0));
            st = $urandom_range(12, 0);
            sp = $urandom_range(40, 0);
            mp = $urandom_range(40, 0);
            dc = $urandom_range(15, 0);
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(300, 1)) : 0;
            run_move(d, h, st, sp, mp, dc, hd, ab, pk, 0);
        end

        run_move(1, 1, 8, 20, 20, 0, 1, 0, 0, 45);
        hold_en = 1'b0;
        run_move(1, 0, 3, 5, 3, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
